phase_scan_ctrl: RTL

//  Receiver phase-acquisition scheduler for the QPSK loopback top. Sweeps the rx

---
 rtl/phase_scan_ctrl.sv | 196 +++++++++++++++++++
 1 files changed

// File: rtl/phase_scan_ctrl.sv
// phase_scan_ctrl
//   Receiver phase-acquisition scheduler. Steps the rx decimation phase through
//   every candidate. For each phase it waits out a settle window while the rx
//   filter flushes, then counts I+Q symbol errors over a fixed measurement
//   window. After the last phase it locks onto the phase with the fewest errors.
//   All outputs are registered.
// Ports
//   clk, rst      clock; asynchronous active-low reset
//   i_start       begin a scan (honoured only in IDLE or LOCKED)
//   i_abort       return to IDLE (takes priority over i_start)
//   i_sym_tick    one-clock strobe per symbol; all windows count these
//   i_err_r/i     I/Q symbol mismatch flags, valid together with i_sym_tick
//   o_phase       rx phase select
//   o_rx_enable   rx datapath enable
//   o_ber_rst_n   active-low reset to the BER checkers
//   o_busy        scan in progress
//   o_locked      best phase applied
//   o_best_err    error count of the chosen phase
module phase_scan_ctrl #(
  parameter int N_PHASES    = 4,
  parameter int PH_W        = 2,
  parameter int SETTLE_SYMS = 32,
  parameter int WINDOW_SYMS = 1024,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_start,
  input  logic             i_abort,
  input  logic             i_sym_tick,
  input  logic             i_err_r,
  input  logic             i_err_i,
  output logic [PH_W-1:0]  o_phase,
  output logic             o_rx_enable,
  output logic             o_ber_rst_n,
  output logic             o_busy,
  output logic             o_locked,
  output logic [CNT_W-1:0] o_best_err
);

  localparam int MAXS = (WINDOW_SYMS > SETTLE_SYMS) ? WINDOW_SYMS : SETTLE_SYMS;
  localparam int TW   = $clog2(MAXS + 1);
  localparam logic [TW-1:0]    SET_LAST = TW'(SETTLE_SYMS - 1);
  localparam logic [TW-1:0]    WIN_LAST = TW'(WINDOW_SYMS - 1);
  localparam logic [PH_W-1:0]  PH_LAST  = PH_W'(N_PHASES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  typedef enum logic [2:0] {S_IDLE, S_SETTLE, S_MEASURE, S_EVAL, S_LOCKED} state_t;

  state_t           state_q, state_d;
  logic [PH_W-1:0]  phase_q, phase_d;
  logic [PH_W-1:0]  best_ph_q, best_ph_d;
  logic [CNT_W-1:0] best_err_q, best_err_d;
  logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
  logic [TW-1:0]    tick_q, tick_d;
  logic             rx_en_q, rx_en_d;
  logic             ber_q, ber_d;
  logic             busy_q, busy_d;
  logic             locked_q, locked_d;

  logic             go, set_done, win_done, better;
  logic [PH_W-1:0]  win_ph;
  logic [CNT_W:0]   err_sum;
  logic [CNT_W-1:0] err_sat;

  assign go       = i_start & ~i_abort & ((state_q == S_IDLE) | (state_q == S_LOCKED));
  assign set_done = i_sym_tick & (tick_q == SET_LAST);
  assign win_done = i_sym_tick & (tick_q == WIN_LAST);
  // strict compare: on a tie the earlier (lower) phase stays best
  assign better   = err_cnt_q < best_err_q;
  assign win_ph   = better ? phase_q : best_ph_q;
  // one guard bit catches overflow of the 0..2 increment
  assign err_sum  = {1'b0, err_cnt_q} + (CNT_W+1)'(i_err_r) + (CNT_W+1)'(i_err_i);
  assign err_sat  = err_sum[CNT_W] ? CNT_MAX : err_sum[CNT_W-1:0];

  // state register plus datapath registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      phase_q    <= '0;
      best_ph_q  <= '0;
      best_err_q <= '1;
      err_cnt_q  <= '0;
      tick_q     <= '0;
      rx_en_q    <= 1'b0;
      ber_q      <= 1'b0;
      busy_q     <= 1'b0;
      locked_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      phase_q    <= phase_d;
      best_ph_q  <= best_ph_d;
      best_err_q <= best_err_d;
      err_cnt_q  <= err_cnt_d;
      tick_q     <= tick_d;
      rx_en_q    <= rx_en_d;
      ber_q      <= ber_d;
      busy_q     <= busy_d;
      locked_q   <= locked_d;
    end
  end

  // next-state
  always_comb begin
    state_d = state_q;
    if (i_abort) state_d = S_IDLE;
    else begin
      case (state_q)
        S_IDLE:    if (i_start)  state_d = S_SETTLE;
        S_SETTLE:  if (set_done) state_d = S_MEASURE;
        S_MEASURE: if (win_done) state_d = S_EVAL;
        S_EVAL:    state_d = (phase_q == PH_LAST) ? S_LOCKED : S_SETTLE;
        S_LOCKED:  if (i_start)  state_d = S_SETTLE;
        default:   state_d = S_IDLE;
      endcase
    end
  end

  // registered outputs and counters
  always_comb begin
    phase_d    = phase_q;
    best_ph_d  = best_ph_q;
    best_err_d = best_err_q;
    err_cnt_d  = err_cnt_q;
    tick_d     = tick_q;
    rx_en_d    = rx_en_q;
    ber_d      = ber_q;
    busy_d     = busy_q;
    locked_d   = locked_q;
    if (i_abort) begin
      // phase select is left where it was
      rx_en_d  = 1'b0;
      ber_d    = 1'b0;
      busy_d   = 1'b0;
      locked_d = 1'b0;
    end else if (go) begin
      phase_d    = '0;
      best_ph_d  = '0;
      best_err_d = '1;
      err_cnt_d  = '0;
      tick_d     = '0;
      rx_en_d    = 1'b1;
      ber_d      = 1'b0;
      busy_d     = 1'b1;
      locked_d   = 1'b0;
    end else begin
      case (state_q)
        S_SETTLE: if (i_sym_tick) begin
          if (set_done) begin
            tick_d    = '0;
            err_cnt_d = '0;
            ber_d     = 1'b1;
          end else tick_d = tick_q + TW'(1);
        end
        S_MEASURE: if (i_sym_tick) begin
          // the final tick's errors still land in the count
          err_cnt_d = err_sat;
          if (win_done) begin
            tick_d = '0;
            ber_d  = 1'b0;
          end else tick_d = tick_q + TW'(1);
        end
        S_EVAL: begin
          if (better) begin
            best_err_d = err_cnt_q;
            best_ph_d  = phase_q;
          end
          tick_d = '0;
          if (phase_q == PH_LAST) begin
            phase_d  = win_ph;
            busy_d   = 1'b0;
            locked_d = 1'b1;
          end else phase_d = phase_q + PH_W'(1);
        end
        S_LOCKED: begin
          // BER checkers stay in reset while the new phase flushes through
          if (i_sym_tick && !ber_q) begin
            if (set_done) begin
              ber_d  = 1'b1;
              tick_d = '0;
            end else tick_d = tick_q + TW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign o_phase     = phase_q;
  assign o_rx_enable = rx_en_q;
  assign o_ber_rst_n = ber_q;
  assign o_busy      = busy_q;
  assign o_locked    = locked_q;
  assign o_best_err  = best_err_q;

endmodule
